// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_ctrl
//  Description : Big-endian data memory for the MIPS memory stage. Accepts
//                one read or write per transaction, inserts WAIT_STATES extra
//                cycles, then returns a one-cycle ready pulse with load data
//                and an error flag. Word/halfword/byte access sizes.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_ctrl #(
    parameter int DEPTH       = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_read,
    input  logic        ram_write,
    input  logic [1:0]  ram_size,
    input  logic [31:0] ram_adr,
    input  logic [31:0] ram_data,
    output logic [31:0] ram_word,
    output logic        ram_ready,
    output logic        ram_err
);

    localparam int          IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] ADR_LIMIT = 33'(4 * DEPTH);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

    // Access size encoding on ram_size
    localparam logic [1:0] SZ_WORD  = 2'd0;
    localparam logic [1:0] SZ_BYTES = 2'd1;
    localparam logic [1:0] SZ_HALF  = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  wait_cnt;
    logic        req_rd;
    logic        req_wr;
    logic [1:0]  req_size;
    logic [31:0] req_adr;
    logic [31:0] req_data;

    logic [31:0] mem [DEPTH];

    logic [IDX_W-1:0] word_idx;
    logic [31:0]      cur_word;
    logic [7:0]       sel_byte;
    logic [15:0]      sel_half;
    logic             access_err;
    logic [31:0]      load_val;
    logic [31:0]      store_val;

    // Out-of-range indices are only formed when access_err is set, so the
    // memory is never touched with them.
    assign word_idx = req_adr[IDX_W+1:2];
    assign cur_word = mem[word_idx];

    // Decode error conditions and build load/store values for the captured request
    always_comb begin
        access_err = 1'b0;
        sel_byte   = 8'h00;
        sel_half   = 16'h0000;
        load_val   = 32'h0000_0000;
        store_val  = cur_word;

        if (req_rd && req_wr)                          access_err = 1'b1;
        if ({1'b0, req_adr} >= ADR_LIMIT)              access_err = 1'b1;
        if (req_size == SZ_WORD && req_adr[1:0] != 2'b00) access_err = 1'b1;
        if (req_size == SZ_HALF && req_adr[0])         access_err = 1'b1;

        // Big-endian: byte offset 0 lives in the most significant lane
        case (req_adr[1:0])
            2'd0:    sel_byte = cur_word[31:24];
            2'd1:    sel_byte = cur_word[23:16];
            2'd2:    sel_byte = cur_word[15:8];
            default: sel_byte = cur_word[7:0];
        endcase
        sel_half = req_adr[1] ? cur_word[15:0] : cur_word[31:16];

        case (req_size)
            SZ_WORD:  load_val = cur_word;
            SZ_BYTES: load_val = {{24{sel_byte[7]}}, sel_byte};
            SZ_HALF:  load_val = {16'h0000, sel_half};
            default:  load_val = {24'h000000, sel_byte};
        endcase

        case (req_size)
            SZ_WORD: store_val = req_data;
            SZ_HALF: begin
                if (req_adr[1]) store_val[15:0]  = req_data[15:0];
                else            store_val[31:16] = req_data[15:0];
            end
            default: begin
                case (req_adr[1:0])
                    2'd0:    store_val[31:24] = req_data[7:0];
                    2'd1:    store_val[23:16] = req_data[7:0];
                    2'd2:    store_val[15:8]  = req_data[7:0];
                    default: store_val[7:0]   = req_data[7:0];
                endcase
            end
        endcase
    end

    // Transaction FSM, registered outputs and memory array
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            wait_cnt  <= 4'd0;
            req_rd    <= 1'b0;
            req_wr    <= 1'b0;
            req_size  <= 2'd0;
            req_adr   <= 32'h0000_0000;
            req_data  <= 32'h0000_0000;
            ram_word  <= 32'h0000_0000;
            ram_ready <= 1'b0;
            ram_err   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'(i);
            end
        end else begin
            case (state)
                IDLE: begin
                    if (ram_read || ram_write) begin
                        req_rd   <= ram_read;
                        req_wr   <= ram_write;
                        req_size <= ram_size;
                        req_adr  <= ram_adr;
                        req_data <= ram_data;
                        wait_cnt <= WAIT_INIT;
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else begin
                        ram_ready <= 1'b1;
                        if (access_err) begin
                            ram_err  <= 1'b1;
                            ram_word <= 32'h0000_0000;
                        end else if (req_wr) begin
                            mem[word_idx] <= store_val;
                        end else begin
                            ram_word <= load_val;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    ram_ready <= 1'b0;
                    ram_err   <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
